// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
//   Shared definitions for the serial-RGB LCD driver: default panel timing,
//   derived line/frame totals, the RGB888 pixel type, the byte-phase enum
//   and a byte-select helper used by the serialiser.
//   No ports (package).
package lcd_timing_pkg;

    // Default panel timing. Horizontal values are in dot clocks except
    // H_ACTIVE_DEF, which is in pixels; each pixel takes three dot clocks.
    localparam int H_ACTIVE_DEF = 320;
    localparam int H_FP_DEF     = 80;
    localparam int H_SYNC_DEF   = 60;
    localparam int H_BP_DEF     = 180;
    localparam int V_ACTIVE_DEF = 240;
    localparam int V_FP_DEF     = 4;
    localparam int V_SYNC_DEF   = 1;
    localparam int V_BP_DEF     = 17;

    localparam int H_TOT_DEF = 3 * H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOT_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Byte index within a pixel slot.
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    // Component select: 0 = R, 1 = G, anything else = B.
    function automatic logic [7:0] rgb_byte(input rgb888_t px, input logic [1:0] idx);
        case (idx)
            2'd0:    return px.r;
            2'd1:    return px.g;
            default: return px.b;
        endcase
    endfunction

endpackage

// File: rtl/lcd_rgb_serialiser.sv
// lcd_rgb_serialiser
//   Holds the pixel captured at the start of a slot and selects the byte for
//   the current phase. On the load cycle the byte comes straight from the
//   incoming pixel so the first byte needs no extra register stage; the
//   remaining bytes come from the holding register.
//   Optional build macro LCD_LINE_ROTATE_EN adds a per-line rotation input
//   that shifts the byte order (R,G,B / G,B,R / B,R,G).
// Ports:
//   clk, reset  - dot clock, synchronous active-high reset
//   phase       - byte index within the pixel slot
//   load        - capture strobe (first byte of a slot)
//   pixel       - pixel to capture on load
//   rot         - (LCD_LINE_ROTATE_EN only) line rotation 0..2
//   data        - selected byte, combinational
module lcd_rgb_serialiser
    import lcd_timing_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  phase_t     phase,
    input  logic       load,
    input  rgb888_t    pixel,
`ifdef LCD_LINE_ROTATE_EN
    input  logic [1:0] rot,
`endif
    output logic [7:0] data
);

    rgb888_t    hold;
    logic [1:0] sel;
`ifdef LCD_LINE_ROTATE_EN
    logic [2:0] sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (load) begin
            hold <= pixel;
        end
    end

    always_comb begin
        sel = phase;
`ifdef LCD_LINE_ROTATE_EN
        // (phase + rot) mod 3; both operands are at most 2.
        sum = {1'b0, phase} + {1'b0, rot};
        sel = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
`endif
        data = load ? rgb_byte(pixel, sel) : rgb_byte(hold, sel);
    end

endmodule

// File: rtl/lcd_serial_rgb_driver.sv
// lcd_serial_rgb_driver
//   Timing generator and pixel serialiser for an 8-bit serial-RGB LCD.
//   Horizontal/vertical counters run continuously; each active pixel is
//   sent as three dot clocks (R, G, B). All panel outputs are registered,
//   so outputs in cycle N+1 reflect the counters in cycle N.
//   Optional build macro LCD_LINE_ROTATE_EN rotates the byte order per line
//   (line%3 == 0: R,G,B; 1: G,B,R; 2: B,R,G).
//
//   Upstream handshake: pix_ready is a combinational decode of the counters
//   (active region, first byte of a slot). A transfer happens in any cycle
//   with pix_valid && pix_ready. If pix_ready is high and pix_valid is low,
//   UNDERFLOW_RGB is sent instead and the sticky underflow flag is set.
//   No pixel is taken while pix_ready is low.
// Ports:
//   clk, reset   - dot clock, synchronous active-high reset
//   pix_rgb      - upstream pixel {R,G,B}
//   pix_valid    - upstream pixel valid
//   pix_ready    - block takes a pixel this cycle
//   frame_start  - one-cycle pulse with the first active byte of a frame
//   lcd_dat      - serial RGB byte (0 outside active bytes)
//   lcd_hsync    - active-low horizontal sync
//   lcd_vsync    - active-low vertical sync
//   lcd_den      - data enable
//   underflow    - sticky, set when a needed pixel was not valid
module lcd_serial_rgb_driver
    import lcd_timing_pkg::*;
#(
    parameter int          H_ACTIVE      = H_ACTIVE_DEF,
    parameter int          H_FP          = H_FP_DEF,
    parameter int          H_SYNC        = H_SYNC_DEF,
    parameter int          H_BP          = H_BP_DEF,
    parameter int          V_ACTIVE      = V_ACTIVE_DEF,
    parameter int          V_FP          = V_FP_DEF,
    parameter int          V_SYNC        = V_SYNC_DEF,
    parameter int          V_BP          = V_BP_DEF,
    parameter logic [23:0] UNDERFLOW_RGB = 24'h000000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pix_rgb,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic [7:0]  lcd_dat,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_den,
    output logic        underflow
);

    localparam int H_A   = 3 * H_ACTIVE;
    localparam int H_TOT = H_A + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_A);
    localparam logic [HW-1:0] HS_START = HW'(H_A + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_A + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcount, hcount_next;
    logic [VW-1:0] vcount, vcount_next;
    phase_t        phase, phase_next;
`ifdef LCD_LINE_ROTATE_EN
    logic [1:0]    rot, rot_next;
`endif

    logic          active;
    logic          hsync_on;
    logic          vsync_on;
    rgb888_t       pixel;
    logic [7:0]    ser_byte;

    // State register: counters, byte phase and (optionally) line rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
            phase  <= PH_R;
`ifdef LCD_LINE_ROTATE_EN
            rot    <= '0;
`endif
        end else begin
            hcount <= hcount_next;
            vcount <= vcount_next;
            phase  <= phase_next;
`ifdef LCD_LINE_ROTATE_EN
            rot    <= rot_next;
`endif
        end
    end

    // Next-state logic. Phase is forced back to R at the start of every line
    // because the line total need not be a multiple of three.
    always_comb begin
        hcount_next = hcount + 1'b1;
        vcount_next = vcount;
        case (phase)
            PH_R:    phase_next = PH_G;
            PH_G:    phase_next = PH_B;
            default: phase_next = PH_R;
        endcase
`ifdef LCD_LINE_ROTATE_EN
        rot_next = rot;
`endif
        if (hcount == H_LAST) begin
            hcount_next = '0;
            phase_next  = PH_R;
            vcount_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
`ifdef LCD_LINE_ROTATE_EN
            // Tracks vcount % 3; cleared at frame wrap so line 0 is always R,G,B.
            if (vcount == V_LAST || rot == 2'd2) begin
                rot_next = '0;
            end else begin
                rot_next = rot + 1'b1;
            end
`endif
        end
    end

    // Output decode from the current counters.
    always_comb begin
        active    = (hcount < H_ACT) && (vcount < V_ACT);
        pix_ready = active && (phase == PH_R) && !reset;
        pixel     = pix_valid ? pix_rgb : UNDERFLOW_RGB;
        hsync_on  = (hcount >= HS_START) && (hcount < HS_END);
        vsync_on  = (vcount >= VS_START) && (vcount < VS_END);
    end

    lcd_rgb_serialiser u_ser (
        .clk   (clk),
        .reset (reset),
        .phase (phase),
        .load  (pix_ready),
        .pixel (pixel),
`ifdef LCD_LINE_ROTATE_EN
        .rot   (rot),
`endif
        .data  (ser_byte)
    );

    // Single output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_dat     <= 8'h00;
            lcd_hsync   <= 1'b1;
            lcd_vsync   <= 1'b1;
            lcd_den     <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            lcd_dat     <= active ? ser_byte : 8'h00;
            lcd_hsync   <= !hsync_on;
            lcd_vsync   <= !vsync_on;
            lcd_den     <= active;
            frame_start <= (hcount == '0) && (vcount == '0);
            if (pix_ready && !pix_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_serial_rgb_driver.sv
`timescale 1ns/1ps
module tb_lcd_serial_rgb_driver;

    // Reduced panel so several whole frames fit in a short run.
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 6;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 2;
    localparam int H_A      = 3 * H_ACTIVE;
    localparam int H_TOT    = H_A + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOT * V_TOT;
    localparam logic [23:0] UF_RGB = 24'h000000;
`ifdef LCD_LINE_ROTATE_EN
    localparam logic [23:0] CONST_PX = 24'h112233;
`else
    localparam logic [23:0] CONST_PX = 24'hA5C33C;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] pix_rgb = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        frame_start;
    logic [7:0]  lcd_dat;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        lcd_den;
    logic        underflow;

    always #5 clk = ~clk;

    lcd_serial_rgb_driver #(
        .H_ACTIVE      (H_ACTIVE),
        .H_FP          (H_FP),
        .H_SYNC        (H_SYNC),
        .H_BP          (H_BP),
        .V_ACTIVE      (V_ACTIVE),
        .V_FP          (V_FP),
        .V_SYNC        (V_SYNC),
        .V_BP          (V_BP),
        .UNDERFLOW_RGB (UF_RGB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_rgb     (pix_rgb),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .frame_start (frame_start),
        .lcd_dat     (lcd_dat),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_den     (lcd_den),
        .underflow   (underflow)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];     // expected bytes while lcd_den is high
    logic [4:0] ctl_q[$];     // per cycle {den, hsync, vsync, frame_start, underflow}
    int checks = 0;
    int passed = 0;
    int mt = 0;               // model position: dot clocks since frame origin
    bit uf_model = 1'b0;
    int xfers = 0;
    int den_cnt = 0;
    int vs_low_cnt = 0;
    int mon_cyc = 0;
    int fs_prev = -1;
    int fs_period = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else if (checks - passed <= 50) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [23:0] px, input int k);
        logic [23:0] t;
        t = px >> (16 - 8 * k);
        return t[7:0];
    endfunction

    // ---------------- driver + reference model ----------------
    // The model places the panel from the elapsed dot clocks alone:
    // h = mt % H_TOT, v = (mt / H_TOT) % V_TOT.
    task automatic step(input bit rst, input bit vld, input logic [23:0] rgb);
        int h;
        int v;
        int rot;
        bit act;
        bit slot;
        bit hs_n;
        bit vs_n;
        logic [23:0] px;
        @(negedge clk);
        reset = rst;
        pix_valid = vld;
        pix_rgb = rgb;
        #2;
        h = mt % H_TOT;
        v = (mt / H_TOT) % V_TOT;
        act = (h < H_A) && (v < V_ACTIVE);
        slot = act && (h % 3 == 0) && !rst;
        check("pix_ready", 32'(pix_ready), 32'(slot));
        if (pix_ready && pix_valid) xfers++;
        if (rst) begin
            uf_model = 1'b0;
            mt = 0;
            ctl_q.push_back(5'b01100);
        end else begin
            if (slot) begin
                px = vld ? rgb : UF_RGB;
                if (!vld) uf_model = 1'b1;
                rot = 0;
`ifdef LCD_LINE_ROTATE_EN
                rot = v % 3;
`endif
                for (int j = 0; j < 3; j++) exp_q.push_back(byte_of(px, (j + rot) % 3));
            end
            hs_n = !((h >= H_A + H_FP) && (h < H_A + H_FP + H_SYNC));
            vs_n = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
            ctl_q.push_back({act, hs_n, vs_n, (h == 0) && (v == 0), uf_model});
            mt++;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                check("lcd_den", 32'(lcd_den), 32'(e[4]));
                check("lcd_hsync", 32'(lcd_hsync), 32'(e[3]));
                check("lcd_vsync", 32'(lcd_vsync), 32'(e[2]));
                check("frame_start", 32'(frame_start), 32'(e[1]));
                check("underflow", 32'(underflow), 32'(e[0]));
                if (lcd_den) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL lcd_dat: got %0h expected nothing queued (t=%0t)", lcd_dat, $time);
                    end else begin
                        check("lcd_dat", 32'(lcd_dat), 32'(exp_q.pop_front()));
                    end
                    den_cnt++;
                end else begin
                    check("lcd_dat_idle", 32'(lcd_dat), 32'h0);
                end
                if (!lcd_vsync) vs_low_cnt++;
                if (frame_start) begin
                    if (fs_prev >= 0) fs_period = mon_cyc - fs_prev;
                    fs_prev = mon_cyc;
                end
                mon_cyc++;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- stimulus ----------------
    initial begin
        int x0;
        int d0;
        int vs0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h0);

        // Frame 0: constant pixel, always valid; count handshakes.
        xfers = 0;
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, CONST_PX);
        check("frame0_xfers", 32'(xfers), 32'(V_ACTIVE * H_ACTIVE));

        // Frame 1: random pixels, one missing pixel at line 10, pixel 5.
        x0 = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 10 * H_TOT) x0 = xfers;
            if (i == 11 * H_TOT) check("line10_xfers", 32'(xfers - x0), 32'(H_ACTIVE - 1));
            step(1'b0, !(i == 10 * H_TOT + 5 * 3), 24'($urandom));
        end

        // Frame 2: random pixels with random gaps.
        for (int i = 0; i < FRAME; i++) step(1'b0, ($urandom_range(3, 0) != 0), 24'($urandom));

        // Frame 3: one-cycle reset mid-line at line 8, at a pixel boundary.
        for (int i = 0; i < 8 * H_TOT + 12; i++) step(1'b0, 1'b1, 24'($urandom));
        step(1'b1, 1'b1, 24'($urandom));

        // Frame 4: a normal frame after reset, then into the next frame's blanking.
        d0 = den_cnt;
        vs0 = vs_low_cnt;
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 24'($urandom));
        check("frame_den_cycles", 32'(den_cnt - d0), 32'(V_ACTIVE * H_A));
        check("frame_vsync_low", 32'(vs_low_cnt - vs0), 32'(V_SYNC * H_TOT));
        for (int i = 0; i < H_A + 4; i++) step(1'b0, 1'b1, 24'($urandom));

        @(negedge clk);
        #3;
        check("frame_start_period", 32'(fs_period), 32'(FRAME));
        check("bytes_drained", 32'(exp_q.size()), 32'h0);
        check("ctl_drained", 32'(ctl_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
